cbus_arbiter: RTL

Sequences the single shared cache bus (cbus) between several cache-side requesters (ICache, DCache, later uncached/MMIO paths). It grants exactly one requester at a time, forwards its `cbus_req_t` downstream, routes `cbus_resp_t` back, and holds the grant for the whole burst. It sits between the caches and the memory-side bus bridge in the core top level.

---
 rtl/cbus_arbiter_pkg.sv | 43 ++++
 rtl/cbus_arb_picker.sv | 50 +++++
 rtl/cbus_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Cache-bus request/response types and arbiter helpers shared by the cbus
// arbiter and the caches that drive it.
package cbus_arbiter_pkg;

  typedef enum logic [2:0] {
    CBUS_SZ_BYTE  = 3'd0,
    CBUS_SZ_HALF  = 3'd1,
    CBUS_SZ_WORD  = 3'd2,
    CBUS_SZ_DWORD = 3'd3
  } cbus_size_t;

  // len counts beats in the burst (1 = single beat).
  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cbus_arb_state_t;

  localparam int CBUS_NUM_REQ_DEFAULT = 2;

  // Index width for n requesters; never narrower than one bit.
  function automatic int cbus_arb_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CBUS_ARB_IDX_W = cbus_arb_idx_w(CBUS_NUM_REQ_DEFAULT);

endpackage

// File: rtl/cbus_arb_picker.sv
// Combinational winner selection: rotate the valid vector so the pointer sits
// at bit 0, take the lowest set bit, then rotate the index back.
module cbus_arb_picker
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                 valid,
  input  logic [cbus_arb_idx_w(NUM_REQ)-1:0] ptr,
  output logic [cbus_arb_idx_w(NUM_REQ)-1:0] winner,
  output logic                               any
);

  localparam int IDX_W = cbus_arb_idx_w(NUM_REQ);
  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot_s;
  logic [IDX_W-1:0]   enc_s;
  logic [IDX_W:0]     sum_s;

  function automatic int wrap_idx(input int j);
    return (j >= NUM_REQ) ? (j - NUM_REQ) : j;
  endfunction

  // Rotate so that requester 'ptr' lands at position 0.
  always_comb begin
    rot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        rot_s[i] = rot_s[i] | (valid[j] && (j == wrap_idx(i + int'(ptr))));
      end
    end
  end

  // Lowest rotated position wins.
  always_comb begin
    enc_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      enc_s = rot_s[i] ? IDX_W'(i) : enc_s;
    end
  end

  // Undo the rotation with a modulo-NUM_REQ add.
  always_comb begin
    sum_s  = {1'b0, enc_s} + {1'b0, ptr};
    winner = (sum_s >= NUM_W) ? IDX_W'(sum_s - NUM_W) : sum_s[IDX_W-1:0];
    any    = |valid;
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Shared cache-bus arbiter: grants one requester per burst and holds the grant
// until ready&&last. Define CBUS_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_REQ],
  output cbus_resp_t iresps [NUM_REQ],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int IDX_W = cbus_arb_idx_w(NUM_REQ);

  cbus_arb_state_t    state_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   ptr_s;
  logic [IDX_W-1:0]   winner_s;
  logic               any_s;
  logic               busy_s;
  logic               burst_end_s;
  logic [NUM_REQ-1:0] valid_s;

`ifdef CBUS_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] next_ptr_s;

  assign ptr_s      = ptr_r;
  assign next_ptr_s = (owner_r == LAST_IDX) ? '0 : (owner_r + IDX_W'(1));
`endif

  assign busy_s      = (state_r == BUSY);
  assign burst_end_s = oresp.ready && oresp.last;

  // Gather request valids for the picker.
  always_comb begin
    valid_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_s[i] = ireqs[i].valid;
    end
  end

  cbus_arb_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid  (valid_s),
    .ptr    (ptr_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // Grant FSM: latch a winner in IDLE, hold it until the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      owner_r <= '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      ptr_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            owner_r <= winner_s;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (burst_end_s) begin
            state_r <= IDLE;
`ifndef CBUS_ARB_FIXED_PRIO_EN
            ptr_r   <= next_ptr_s;
`endif
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Downstream request is the owner's request while busy, zero otherwise.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oreq = (busy_s && (owner_r == IDX_W'(i))) ? ireqs[i] : oreq;
    end
  end

  // Responses reach only the owner; spurious responses in IDLE are dropped.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = (busy_s && (owner_r == IDX_W'(i))) ? oresp : '0;
    end
  end

endmodule
